// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder. A single full-adder cell is reused every
// cycle, and a carry register closes the loop between bit positions.
// The result is presented as a registered parallel word plus carry-out,
// with a start/busy/done handshake toward the controlling logic.

// One-bit full-adder stage, reused once per clock by serial_adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_res_next;

    fulladder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c)
    );

    // Partial result shifts right with the new sum bit entering at the MSB,
    // so after WIDTH steps bit 0 of the operands sits at bit 0 of the word.
    // Written as shift-and-or so that WIDTH=1 needs no special case.
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    // Control FSM plus datapath registers; outputs change only on completion or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        // Final bit: publish the whole word, including this bit.
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum;
    assign cout    = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for the handshake,
// timing and randomized arithmetic, plus a 1-bit instance checked exhaustively.
// Expected results come from plain integer addition a + b + cin.
module tb_serial_adder;
    logic       clk;
    logic       rst_n;

    logic       start8, c8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1, a1, b1, c1;
    logic       busy1, done1, cout1;
    logic       sum1;

    int total;
    int passed;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a_in    (a8),
        .b_in    (b8),
        .cin     (c8),
        .busy    (busy8),
        .done    (done8),
        .sum_out (sum8),
        .cout    (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .a_in    (a1),
        .b_in    (b1),
        .cin     (c1),
        .busy    (busy1),
        .done    (done1),
        .sum_out (sum1),
        .cout    (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Launch one 8-bit add and observe it until done (bounded).
    // res = {cout, sum_out} at done; lat = edges from accept to done.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [8:0] res, output int lat, output int busy_bad);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        lat = 0;
        busy_bad = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 !== 1'b1) busy_bad++;
            cyc();
            lat++;
        end
        res = {cout8, sum8};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        repeat (2) cyc();
        total++;
        if ({busy8, done8, cout8, sum8} !== 11'h000)
            $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h required all 0", busy8, done8, cout8, sum8);
        else passed++;
        total++;
        if ({busy1, done1, cout1, sum1} !== 4'h0)
            $display("FAIL reset1: got busy=%b done=%b cout=%b sum=%b required all 0", busy1, done1, cout1, sum1);
        else passed++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [8:0] res;
        int lat, bb;
        add8(8'h5A, 8'h3C, 1'b0, res, lat, bb);
        total++;
        if (res !== 9'h096) $display("FAIL basic_result: got %h required %h", res, 9'h096);
        else passed++;
        total++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d required %0d", lat, 8);
        else passed++;
        total++;
        if (bb !== 0 || busy8 !== 1'b0)
            $display("FAIL basic_busy: got %0d low-busy cycles, busy at done=%b required 0/0", bb, busy8);
        else passed++;
        cyc();
        total++;
        if (done8 !== 1'b0 || sum8 !== 8'h96)
            $display("FAIL basic_done_clears: got done=%b sum=%h required 0/96", done8, sum8);
        else passed++;
    endtask

    task automatic test_carry();
        logic [8:0] res;
        int lat, bb;
        add8(8'hFF, 8'h01, 1'b0, res, lat, bb);
        total++;
        if (res !== 9'h100) $display("FAIL carry_ff_01: got %h required %h", res, 9'h100);
        else passed++;
        add8(8'hFF, 8'hFF, 1'b1, res, lat, bb);
        total++;
        if (res !== 9'h1FF) $display("FAIL carry_ff_ff_1: got %h required %h", res, 9'h1FF);
        else passed++;
        cyc();
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic c;
        logic [8:0] res, exp;
        int lat, bb;
        int bad_res, bad_lat;
        bad_res = 0; bad_lat = 0;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            exp = 9'(int'(a) + int'(b) + int'(c));
            add8(a, b, c, res, lat, bb);
            total++;
            if (res !== exp) begin
                $display("FAIL random_add %h+%h+%b: got %h required %h", a, b, c, res, exp);
                bad_res++;
            end else passed++;
            if (lat !== 8 || bb !== 0) bad_lat++;
            if ((i % 3) == 0) cyc();
        end
        total++;
        if (bad_lat !== 0) $display("FAIL random_timing: got %0d bad ops required 0", bad_lat);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int lat;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
        cyc();
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (lat == 3) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h77; c8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            cyc();
            lat++;
        end
        start8 = 1'b0;
        total++;
        if ({cout8, sum8} !== 9'h030) $display("FAIL ignore_result: got %h required %h", {cout8, sum8}, 9'h030);
        else passed++;
        total++;
        if (lat !== 8) $display("FAIL ignore_latency: got %0d required %0d", lat, 8);
        else passed++;
        cyc();
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0)
            $display("FAIL ignore_no_restart: got busy=%b done=%b required 0/0", busy8, done8);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic [8:0] res, first;
        int lat, bb, hold_bad;
        a = 8'($urandom_range(2, 255));
        b = 8'($urandom_range(2, 255));
        first = 9'(int'(a) + int'(b) + 1);
        add8(a, b, 1'b1, res, lat, bb);
        total++;
        if (res !== first) $display("FAIL b2b_first: got %h required %h", res, first);
        else passed++;
        // Still in the done cycle: issue the next start now.
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1) $display("FAIL b2b_accept: got busy=%b required 1", busy8);
        else passed++;
        hold_bad = 0;
        for (int i = 1; i < 8; i++) begin
            if ({cout8, sum8} !== first || done8 !== 1'b0) hold_bad++;
            cyc();
        end
        if ({cout8, sum8} !== first) hold_bad++;
        total++;
        if (hold_bad !== 0) $display("FAIL b2b_hold: got %0d bad cycles required 0", hold_bad);
        else passed++;
        cyc();
        total++;
        if (done8 !== 1'b1 || {cout8, sum8} !== 9'h002)
            $display("FAIL b2b_second: got done=%b result=%h required 1/%h", done8, {cout8, sum8}, 9'h002);
        else passed++;
        cyc();
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] res;
        int lat, bb, stray;
        add8(8'hFF, 8'hFF, 1'b1, res, lat, bb);
        total++;
        if (res !== 9'h1FF) $display("FAIL midreset_pre: got %h required %h", res, 9'h1FF);
        else passed++;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy8, done8, cout8, sum8} !== 11'h000)
            $display("FAIL midreset_async: got busy=%b done=%b cout=%b sum=%h required all 0", busy8, done8, cout8, sum8);
        else passed++;
        repeat (2) cyc();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done8 !== 1'b0 || busy8 !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0) $display("FAIL midreset_no_done: got %0d active cycles required 0", stray);
        else passed++;
        add8(8'h0F, 8'h01, 1'b0, res, lat, bb);
        total++;
        if (res !== 9'h010 || lat !== 8)
            $display("FAIL midreset_after: got %h lat %0d required %h lat 8", res, lat, 9'h010);
        else passed++;
        cyc();
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            exp = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
            a1 = v[2]; b1 = v[1]; c1 = v[0]; start1 = 1'b1;
            cyc();
            start1 = 1'b0;
            total++;
            if (busy1 !== 1'b1 || done1 !== 1'b0)
                $display("FAIL w1_run_%0d: got busy=%b done=%b required 1/0", i, busy1, done1);
            else passed++;
            cyc();
            total++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || {cout1, sum1} !== exp)
                $display("FAIL w1_result_%0d: got done=%b busy=%b result=%b required 1/0/%b",
                         i, done1, busy1, {cout1, sum1}, exp);
            else passed++;
        end
        cyc();
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
